vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_defer_ctr.sv | 92 +++++++++
 rtl/vram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg -- shared definitions for the video RAM arbiter.
// Holds the arbiter state encoding, the default RAM geometry and the width
// of the CPU defer counter. Imported by vram_defer_ctr and vram_arbiter.
package vram_pkg;

    localparam int AW_DEFAULT = 13;
    localparam int DW_DEFAULT = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VID    = 3'd1,
        ST_CPU_RD = 3'd2,
        ST_CPU_WR = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/vram_defer_ctr.sv
// vram_defer_ctr -- saturating count of cycles a CPU request has been deferred.
// Optional statistics (macro VRAM_ARB_STATS_EN): largest defer count seen and
// a wrapping count of completed CPU accesses.
// Ports:
//   clk_sys, reset       clock, asynchronous active-high reset
//   inc                  CPU pending and not granted this cycle
//   clr                  CPU granted this cycle (takes precedence over inc)
//   at_max               counter has reached MAX_WAIT
//   ack                  (stats only) cpu_ack pulse
//   stat_wait_max        (stats only) largest defer count since reset
//   stat_cpu_cnt         (stats only) number of cpu_ack pulses, wrapping
module vram_defer_ctr
    import vram_pkg::*;
#(
    parameter int MAX_WAIT = 7
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic        at_max
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic        ack,
    output logic [7:0]  stat_wait_max,
    output logic [15:0] stat_cpu_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next defer count: clear on grant, otherwise count up and hold at MAX_C.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Defer count register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_C);

`ifdef VRAM_ARB_STATS_EN
    logic [7:0]  wait_max_q, wait_max_d;
    logic [15:0] cpu_cnt_q, cpu_cnt_d;

    // Running maximum of the defer count and the completed-access tally.
    always_comb begin
        wait_max_d = wait_max_q;
        cpu_cnt_d  = cpu_cnt_q;
        if (cnt_q > wait_max_q) begin
            wait_max_d = cnt_q;
        end else begin
            wait_max_d = wait_max_q;
        end
        if (ack) begin
            cpu_cnt_d = cpu_cnt_q + 16'd1;
        end else begin
            cpu_cnt_d = cpu_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wait_max_q <= 8'd0;
            cpu_cnt_q  <= 16'd0;
        end else begin
            wait_max_q <= wait_max_d;
            cpu_cnt_q  <= cpu_cnt_d;
        end
    end

    assign stat_wait_max = wait_max_q;
    assign stat_cpu_cnt  = cpu_cnt_q;
`endif

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one single-port video RAM between video fetches and
// Z80 CPU accesses. Video wins unless the CPU has been deferred CPU_MAX_WAIT
// cycles; a video request that cannot be issued immediately is held in a
// one-deep latch (newest address overwrites).
// Optional macro VRAM_ARB_STATS_EN adds stat_wait_max / stat_cpu_cnt outputs.
// Ports:
//   clk_sys, reset                  clock, asynchronous active-high reset
//   vid_req/vid_addr                video fetch request pulse and address
//   vid_data/vid_valid              fetched byte and its one-cycle strobe
//   cpu_req/cpu_we/cpu_addr/wdata   CPU request (level, held until cpu_ack)
//   cpu_rdata/cpu_ack/cpu_wait      CPU read data, completion pulse, wait
//   ram_addr/ram_we/ram_din         RAM command (registered)
//   ram_dout                        RAM read data, one cycle after address
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int DW           = DW_DEFAULT,
    parameter int CPU_MAX_WAIT = 7
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [7:0]    stat_wait_max,
    output logic [15:0]   stat_cpu_cnt
`endif
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          lat_valid_q, lat_valid_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic          vid_valid_q, vid_valid_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          op_rd_q, op_rd_d;
    logic          cpu_pend;
    logic          ctr_inc, ctr_clr, at_max;

    // A request is not re-sampled in the cycle its ack is shown.
    assign cpu_pend = cpu_req & ~cpu_ack_q;

    vram_defer_ctr #(.MAX_WAIT(CPU_MAX_WAIT)) u_defer (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .inc           (ctr_inc),
        .clr           (ctr_clr),
        .at_max        (at_max)
`ifdef VRAM_ARB_STATS_EN
        ,
        .ack           (cpu_ack_q),
        .stat_wait_max (stat_wait_max),
        .stat_cpu_cnt  (stat_cpu_cnt)
`endif
    );

    // Arbitration, next state and registered RAM command.
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_din_d   = ram_din_q;
        lat_valid_d = lat_valid_q;
        lat_addr_d  = lat_addr_q;
        vid_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        op_rd_d     = op_rd_q;
        ctr_inc     = 1'b0;
        ctr_clr     = 1'b0;

        // Any video request not issued from IDLE lands in the latch.
        if ((state_q != ST_IDLE) && vid_req) begin
            lat_valid_d = 1'b1;
            lat_addr_d  = vid_addr;
        end else begin
            lat_valid_d = lat_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if ((lat_valid_q | vid_req) && !(cpu_pend && at_max)) begin
                    state_d = ST_VID;
                    ctr_inc = cpu_pend;
                    // The older latched address goes first; a new request takes its slot.
                    if (lat_valid_q) begin
                        ram_addr_d  = lat_addr_q;
                        lat_valid_d = vid_req;
                        lat_addr_d  = vid_req ? vid_addr : lat_addr_q;
                    end else begin
                        ram_addr_d  = vid_addr;
                    end
                end else if (cpu_pend) begin
                    ctr_clr    = 1'b1;
                    ram_addr_d = cpu_addr;
                    op_rd_d    = ~cpu_we;
                    if (cpu_we) begin
                        state_d   = ST_CPU_WR;
                        ram_we_d  = 1'b1;
                        ram_din_d = cpu_wdata;
                    end else begin
                        state_d   = ST_CPU_RD;
                    end
                    if (vid_req) begin
                        lat_valid_d = 1'b1;
                        lat_addr_d  = vid_addr;
                    end else begin
                        lat_valid_d = lat_valid_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VID: begin
                vid_valid_d = 1'b1;
                ctr_inc     = cpu_pend;
                state_d     = ST_IDLE;
            end
            ST_CPU_RD, ST_CPU_WR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                cpu_ack_d = 1'b1;
                state_d   = ST_IDLE;
                if (op_rd_q) begin
                    cpu_rdata_d = ram_dout;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= {AW{1'b0}};
            ram_we_q    <= 1'b0;
            ram_din_q   <= {DW{1'b0}};
            lat_valid_q <= 1'b0;
            lat_addr_q  <= {AW{1'b0}};
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= {DW{1'b0}};
            op_rd_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
            lat_valid_q <= lat_valid_d;
            lat_addr_q  <= lat_addr_d;
            vid_valid_q <= vid_valid_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            op_rd_q     <= op_rd_d;
        end
    end

    // RAM data arrives in the strobe cycle itself, so the byte is passed through.
    assign vid_data  = vid_valid_q ? ram_dout : {DW{1'b0}};
    assign vid_valid = vid_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- self-checking bench for vram_arbiter.
module tb_vram_arbiter;
    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int MAXW = 7;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef VRAM_ARB_STATS_EN
    logic [7:0]    stat_wait_max;
    logic [15:0]   stat_cpu_cnt;
`endif

    vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(MAXW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef VRAM_ARB_STATS_EN
        , .stat_wait_max(stat_wait_max), .stat_cpu_cnt(stat_cpu_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] fpat(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b000} ^ 8'h52;
    endfunction

    // Single-port RAM, one-cycle read latency; 'fill' loads the initial pattern.
    logic       fill = 1'b0;
    logic [7:0] ram_arr [0:8191];
    always @(posedge clk_sys) begin
        if (fill) begin
            for (int i = 0; i < 8192; i++) ram_arr[i] <= fpat(13'(i));
        end else begin
            if (ram_we) ram_arr[ram_addr] <= ram_din;
            ram_dout <= ram_arr[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: scheduled events per cycle number.
    logic [7:0]  mmem [0:8191];
    int          cyc, free_at, ack_at, valid_at, we_at, svc_until, wcnt, wmax, ackcnt;
    bit          lat_v;
    logic [12:0] lat_a, we_a;
    logic [7:0]  we_d, exp_vd, exp_rd, exp_rd_pend;

    task automatic model_reset();
        cyc = 0; free_at = 0; ack_at = -100; valid_at = -100; we_at = -100;
        svc_until = 0; wcnt = 0; wmax = 0; ackcnt = 0; lat_v = 0; lat_a = '0;
        exp_rd = 8'h00; exp_rd_pend = 8'h00;
    endtask

    task automatic step();
        bit pend;
        logic [12:0] va;
        if (wcnt > wmax) wmax = wcnt;
        if (cyc == ack_at) ackcnt++;
        pend = cpu_req && (cyc != ack_at) && (cyc >= svc_until);
        if (cyc >= free_at) begin
            if ((lat_v || vid_req) && !(pend && wcnt == MAXW)) begin
                va = lat_v ? lat_a : vid_addr;
                if (lat_v) begin
                    lat_v = vid_req;
                    if (vid_req) lat_a = vid_addr;
                end
                valid_at = cyc + 2; exp_vd = mmem[va]; free_at = cyc + 2;
                if (pend && wcnt < MAXW) wcnt++;
            end else if (pend) begin
                if (vid_req) begin lat_v = 1; lat_a = vid_addr; end
                wcnt = 0; free_at = cyc + 3; svc_until = cyc + 3; ack_at = cyc + 3;
                if (cpu_we) begin
                    we_at = cyc + 1; we_a = cpu_addr; we_d = cpu_wdata;
                    mmem[cpu_addr] = cpu_wdata; exp_rd_pend = exp_rd;
                end else begin
                    exp_rd_pend = mmem[cpu_addr];
                end
            end
        end else begin
            if (vid_req) begin lat_v = 1; lat_a = vid_addr; end
            if (pend && wcnt < MAXW) wcnt++;
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        if (cyc == ack_at) exp_rd = exp_rd_pend;
        chk("vid_valid", vid_valid, cyc == valid_at);
        if (cyc == valid_at) chk("vid_data", vid_data, exp_vd);
        chk("cpu_ack", cpu_ack, cyc == ack_at);
        chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("ram_we", ram_we, cyc == we_at);
        if (cyc == we_at) begin
            chk("ram_addr_wr", ram_addr, we_a);
            chk("ram_din", ram_din, we_d);
        end
        chk("cpu_wait", cpu_wait, cpu_req && (cyc != ack_at));
    endtask

    task automatic do_reset();
        reset = 1'b1; vid_req = 0; cpu_req = 0; cpu_we = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cpu_txn(input bit we, input logic [12:0] a, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd, output int wes);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = -1; rd = 8'h00; wes = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (ram_we) wes++;
            if (cpu_ack) begin lat = n; rd = cpu_rdata; break; end
        end
        cpu_req = 0; cpu_we = 0;
        step();
        if (ram_we) wes++;
        step();
    endtask

    typedef struct {
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat, wes, vv, ak;
        logic [7:0] rd;

        tbl[0] = '{1'b0, 13'h0100, 8'h00, 8'h5A, 3};
        tbl[1] = '{1'b1, 13'h1FFF, 8'hC3, 8'h00, 3};
        tbl[2] = '{1'b0, 13'h1FFF, 8'h00, 8'hC3, 3};
        tbl[3] = '{1'b0, 13'h0000, 8'h00, 8'h52, 3};
        tbl[4] = '{1'b1, 13'h0000, 8'hA5, 8'h00, 3};
        tbl[5] = '{1'b0, 13'h0000, 8'h00, 8'hA5, 3};

        for (int i = 0; i < 8192; i++) mmem[i] = fpat(13'(i));
        #2 reset = 1'b1;
        fill = 1'b1;
        @(posedge clk_sys);
        #1 fill = 1'b0;
        do_reset();

        // Isolated CPU accesses.
        for (int i = 0; i < 6; i++) begin
            cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, wes);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_we_cycles", i), wes, tbl[i].we ? 1 : 0);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end

        // Video and CPU in the same cycle with an empty defer count.
        do_reset();
        vid_req = 1; vid_addr = 13'h0ABC; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0100;
        vv = -1; ak = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            vid_req = 0;
            if (vid_valid && vv < 0) vv = cyc;
            if (cpu_ack && ak < 0) begin ak = cyc; cpu_req = 0; end
        end
        chk("coinc_vid_valid_cycle", vv, 2);
        chk("coinc_cpu_ack_cycle", ak, 5);

        // Continuous video with a held CPU read.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0200;
        ak = -1;
        for (int n = 0; n < 40; n++) begin
            vid_req = (n < 24); vid_addr = 13'($urandom);
            step();
            if (cpu_ack && ak < 0) begin ak = cyc; cpu_req = 0; end
        end
        chk("starve_ack_cycle", ak, 11);
`ifdef VRAM_ARB_STATS_EN
        chk("stat_wait_max", stat_wait_max, 7);
        chk("stat_cpu_cnt", stat_cpu_cnt, 1);
`endif

        // Reset in the middle of a CPU read.
        do_reset();
        cpu_txn(1'b0, 13'h0100, 8'h00, lat, rd, wes);
        chk("pre_rst_rdata", rd, 8'h5A);
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0300;
        step();
        #2 reset = 1'b1;
        #1;
        chk("abort_cpu_ack", cpu_ack, 0);
        chk("abort_cpu_rdata", cpu_rdata, 0);
        chk("abort_ram_we", ram_we, 0);
        do_reset();
        cpu_txn(1'b0, 13'h0100, 8'h00, lat, rd, wes);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rd, 8'h5A);

        // Random traffic at several video densities.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            int dens;
            dens = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 2 : 8);
            for (int n = 0; n < 500; n++) begin
                vid_req = ($urandom_range(dens - 1) == 0);
                vid_addr = 13'($urandom);
                if (!cpu_req || cpu_ack) begin
                    if ($urandom_range(2) == 0) begin
                        cpu_req = 1; cpu_we = 1'($urandom_range(1));
                        cpu_addr = ($urandom_range(1) == 0) ? 13'($urandom_range(15)) : 13'($urandom);
                        cpu_wdata = 8'($urandom);
                    end else begin
                        cpu_req = 0;
                    end
                end
                step();
            end
        end
        vid_req = 0;
        for (int n = 0; n < 20; n++) begin
            if (cpu_ack) cpu_req = 0;
            step();
        end
`ifdef VRAM_ARB_STATS_EN
        chk("rand_stat_wait_max", stat_wait_max, wmax);
        chk("rand_stat_cpu_cnt", stat_cpu_cnt, ackcnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
